mem_read_arbiter: RTL and testbench

- Shares the single AXI-style memory read channel (read address + read data) between the i_cache and d_cache refill engines.
- Grants one requester at a time and holds the grant until that requester's whole refill burst has returned.
- Routes the returning data beats only to the granted cache.
- Sits between the two caches' read-master ports and the memory read-slave port in mips_core.

---
 rtl/mem_read_arbiter_pkg.sv | 17 +
 rtl/mem_read_arbiter_rr_arbiter_2.sv | 22 ++
 rtl/mem_read_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_read_arbiter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/mem_read_arbiter_pkg.sv
// Shared types and constants for the memory read-channel arbiter.
package mem_read_arbiter_pkg;

    localparam int unsigned LenWidth = 5;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData
    } arb_state_t;

    typedef enum logic {
        ReqI = 1'b0,
        ReqD = 1'b1
    } requester_t;

endpackage

// File: rtl/mem_read_arbiter_rr_arbiter_2.sv
// Two-way round-robin pick. Purely combinational; the caller keeps last_grant.
module rr_arbiter_2
    import mem_read_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  requester_t last_grant,
    output logic       valid,
    output requester_t winner
);

    always_comb begin
        valid  = |req;
        winner = ReqI;
        if (req == 2'b11) begin
            // On a tie, the requester that did not go last wins.
            winner = (last_grant == ReqI) ? ReqD : ReqI;
        end else if (req[1]) begin
            winner = ReqD;
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// Shares one AXI-style read channel between the i_cache and d_cache refill engines,
// holding the grant until the granted burst has fully returned.
module mem_read_arbiter
    import mem_read_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 26,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = LenWidth,
    parameter int unsigned ID_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [ADDR_WIDTH-1:0] i_araddr,
    input  logic [LEN_WIDTH-1:0]  i_arlen,
    input  logic [ID_WIDTH-1:0]   i_arid,
    input  logic                  i_arvalid,
    output logic                  i_arready,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_rvalid,
    input  logic                  i_rready,

    input  logic [ADDR_WIDTH-1:0] d_araddr,
    input  logic [LEN_WIDTH-1:0]  d_arlen,
    input  logic [ID_WIDTH-1:0]   d_arid,
    input  logic                  d_arvalid,
    output logic                  d_arready,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_rvalid,
    input  logic                  d_rready,

    output logic [ADDR_WIDTH-1:0] s_araddr,
    output logic [LEN_WIDTH-1:0]  s_arlen,
    output logic [ID_WIDTH-1:0]   s_arid,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    input  logic                  s_rvalid,
    output logic                  s_rready,

    output logic                  o_busy,
    output logic                  o_protocol_error
);

    arb_state_t           state_q, state_d;
    requester_t           grant_q, grant_d;
    requester_t           last_grant_q, last_grant_d;
    logic [LEN_WIDTH-1:0] count_q, count_d;
    logic                 perr_q, perr_d;

    logic       arb_valid;
    requester_t arb_winner;
    logic       gnt_d;
    logic       sel_arvalid;
    logic       beat;

    rr_arbiter_2 u_rr (
        .req        ({d_arvalid, i_arvalid}),
        .last_grant (last_grant_q),
        .valid      (arb_valid),
        .winner     (arb_winner)
    );

    assign gnt_d       = (grant_q == ReqD);
    assign sel_arvalid = gnt_d ? d_arvalid : i_arvalid;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        count_d      = count_q;
        perr_d       = perr_q;

        s_araddr  = '0;
        s_arlen   = '0;
        s_arid    = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        i_arready = 1'b0;
        d_arready = 1'b0;
        i_rdata   = '0;
        d_rdata   = '0;
        i_rvalid  = 1'b0;
        d_rvalid  = 1'b0;
        beat      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    grant_d = arb_winner;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                s_araddr  = gnt_d ? d_araddr : i_araddr;
                s_arlen   = gnt_d ? d_arlen  : i_arlen;
                s_arid    = gnt_d ? d_arid   : i_arid;
                s_arvalid = sel_arvalid;
                if (gnt_d) d_arready = s_arready;
                else       i_arready = s_arready;
                if (!sel_arvalid) begin
                    // Requester withdrew; re-arbitrate without touching last_grant.
                    state_d = StIdle;
                end else if (s_arready) begin
                    count_d = (s_arlen == '0) ? LEN_WIDTH'(1) : s_arlen;
                    state_d = StData;
                end
            end
            StData: begin
                i_rdata = s_rdata;
                d_rdata = s_rdata;
                if (gnt_d) begin
                    d_rvalid = s_rvalid;
                    s_rready = d_rready;
                end else begin
                    i_rvalid = s_rvalid;
                    s_rready = i_rready;
                end
                beat = s_rvalid & s_rready;
                if (beat) begin
                    count_d = count_q - LEN_WIDTH'(1);
                    if (count_q == LEN_WIDTH'(1)) begin
                        state_d      = StIdle;
                        last_grant_d = grant_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (s_rvalid && state_q != StData) perr_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            grant_q      <= ReqI;
            last_grant_q <= ReqD;
            count_q      <= '0;
            perr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            count_q      <= count_d;
            perr_q       <= perr_d;
        end
    end

    assign o_busy           = (state_q != StIdle);
    assign o_protocol_error = perr_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed per-cycle vector bench for mem_read_arbiter plus a mid-burst reset sequence.
module tb_mem_read_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [25:0] i_araddr = 26'h100, d_araddr = 26'h200, s_araddr;
    logic [4:0]  i_arlen = 5'd4, d_arlen = 5'd4, s_arlen;
    logic [3:0]  i_arid = 4'd1, d_arid = 4'd2, s_arid;
    logic        i_arvalid = 0, d_arvalid = 0, s_arready = 0, s_rvalid = 0;
    logic        i_rready = 0, d_rready = 0;
    logic        i_arready, d_arready, i_rvalid, d_rvalid, s_arvalid, s_rready;
    logic [31:0] s_rdata = '0, i_rdata, d_rdata;
    logic        o_busy, o_protocol_error;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_read_arbiter dut (
        .clk (clk), .rst_n (rst_n),
        .i_araddr (i_araddr), .i_arlen (i_arlen), .i_arid (i_arid), .i_arvalid (i_arvalid),
        .i_arready (i_arready), .i_rdata (i_rdata), .i_rvalid (i_rvalid), .i_rready (i_rready),
        .d_araddr (d_araddr), .d_arlen (d_arlen), .d_arid (d_arid), .d_arvalid (d_arvalid),
        .d_arready (d_arready), .d_rdata (d_rdata), .d_rvalid (d_rvalid), .d_rready (d_rready),
        .s_araddr (s_araddr), .s_arlen (s_arlen), .s_arid (s_arid), .s_arvalid (s_arvalid),
        .s_arready (s_arready), .s_rdata (s_rdata), .s_rvalid (s_rvalid), .s_rready (s_rready),
        .o_busy (o_busy), .o_protocol_error (o_protocol_error)
    );

    // in = {rst, i_arvalid, d_arvalid, s_arready, s_rvalid, i_rready, d_rready}
    // ex = {busy, s_arvalid, i_arready, d_arready, i_rvalid, d_rvalid, s_rready, perr}
    typedef struct {
        logic [6:0]  in;
        logic [31:0] sd;
        logic [7:0]  ex;
        logic [25:0] ea;
        logic [31:0] er;
        logic [4:0]  il;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic [6:0] in, input logic [31:0] sd,
                                input logic [7:0] ex, input logic [25:0] ea,
                                input logic [31:0] er, input logic [4:0] il);
        vec_t v;
        v.in = in; v.sd = sd; v.ex = ex; v.ea = ea; v.er = er; v.il = il;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {24'b0, o_busy, s_arvalid, i_arready, d_arready,
                i_rvalid, d_rvalid, s_rready, o_protocol_error};
    endfunction

    initial begin
        logic [8:0] exp_idlen;

        // I-only burst of 4 beats
        tv.push_back(mk(7'b1_1_0_0_0_0_0, 0, 8'b0000_0000, 0, 0, 4));
        tv.push_back(mk(7'b0_1_0_1_0_0_0, 0, 8'b1110_0000, 26'h100, 0, 4));
        for (int k = 0; k < 4; k++)
            tv.push_back(mk(7'b0_0_0_0_1_1_0, 32'hA + k, 8'b1000_1010, 0, 32'hA + k, 4));
        tv.push_back(mk(7'b0_0_0_0_0_0_0, 0, 8'b0000_0000, 0, 0, 4));
        // Both requesting from reset: I, then D, then I again
        tv.push_back(mk(7'b1_1_1_0_0_0_0, 0, 8'b0000_0000, 0, 0, 4));
        tv.push_back(mk(7'b0_1_1_1_0_0_0, 0, 8'b1110_0000, 26'h100, 0, 4));
        for (int k = 1; k <= 4; k++)
            tv.push_back(mk(7'b0_1_1_0_1_1_1, k, 8'b1000_1010, 0, k, 4));
        tv.push_back(mk(7'b0_1_1_0_0_1_1, 0, 8'b0000_0000, 0, 0, 4));
        tv.push_back(mk(7'b0_1_1_1_0_1_1, 0, 8'b1101_0000, 26'h200, 0, 4));
        for (int k = 5; k <= 8; k++)
            tv.push_back(mk(7'b0_1_1_0_1_1_1, k, 8'b1000_0110, 0, k, 4));
        tv.push_back(mk(7'b0_1_1_0_0_1_1, 0, 8'b0000_0000, 0, 0, 4));
        // I granted but withdraws before the handshake
        tv.push_back(mk(7'b0_0_1_0_0_1_1, 0, 8'b1000_0000, 26'h100, 0, 4));
        tv.push_back(mk(7'b0_0_1_0_0_1_1, 0, 8'b0000_0000, 0, 0, 4));
        // D burst with 3 cycles of backpressure while I waits
        tv.push_back(mk(7'b0_1_1_1_0_1_1, 0, 8'b1101_0000, 26'h200, 0, 4));
        tv.push_back(mk(7'b0_1_0_0_1_1_1, 32'h9, 8'b1000_0110, 0, 32'h9, 4));
        tv.push_back(mk(7'b0_1_0_0_1_1_1, 32'hA, 8'b1000_0110, 0, 32'hA, 4));
        for (int k = 0; k < 3; k++)
            tv.push_back(mk(7'b0_1_0_0_1_1_0, 32'hB, 8'b1000_0100, 0, 32'hB, 4));
        tv.push_back(mk(7'b0_1_0_0_1_1_1, 32'hB, 8'b1000_0110, 0, 32'hB, 4));
        tv.push_back(mk(7'b0_1_0_0_1_1_1, 32'hC, 8'b1000_0110, 0, 32'hC, 4));
        // I granted one cycle later, with arlen=0 meaning a single beat
        tv.push_back(mk(7'b0_1_0_0_0_0_0, 0, 8'b0000_0000, 0, 0, 0));
        tv.push_back(mk(7'b0_1_0_1_0_0_0, 0, 8'b1110_0000, 26'h100, 0, 0));
        tv.push_back(mk(7'b0_0_0_0_1_1_0, 32'h55, 8'b1000_1010, 0, 32'h55, 0));
        tv.push_back(mk(7'b0_0_0_0_0_0_0, 0, 8'b0000_0000, 0, 0, 0));
        // Stray beat in IDLE: not forwarded, error is sticky
        tv.push_back(mk(7'b0_0_0_0_1_0_0, 32'h77, 8'b0000_0000, 0, 0, 4));
        tv.push_back(mk(7'b0_0_0_0_0_0_0, 0, 8'b0000_0001, 0, 0, 4));
        tv.push_back(mk(7'b0_0_0_0_0_0_0, 0, 8'b0000_0001, 0, 0, 4));

        foreach (tv[n]) begin
            @(negedge clk);
            if (tv[n].in[6]) begin
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
            end
            {i_arvalid, d_arvalid, s_arready, s_rvalid, i_rready, d_rready} = tv[n].in[5:0];
            s_rdata = tv[n].sd;
            i_arlen = tv[n].il;
            #1;
            exp_idlen = (tv[n].ea == 26'h100) ? {4'd1, tv[n].il} :
                        (tv[n].ea == 26'h200) ? {4'd2, 5'd4} : 9'd0;
            chk($sformatf("v%0d_ctl", n), outs(), {24'b0, tv[n].ex});
            chk($sformatf("v%0d_addr", n), {6'b0, s_araddr}, {6'b0, tv[n].ea});
            chk($sformatf("v%0d_idlen", n), {23'b0, s_arid, s_arlen}, {23'b0, exp_idlen});
            chk($sformatf("v%0d_irdata", n), i_rdata, tv[n].er);
            chk($sformatf("v%0d_drdata", n), d_rdata, tv[n].er);
        end

        // Async reset after the 2nd of 4 I beats
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        {i_arvalid, d_arvalid, s_arready, s_rvalid, i_rready, d_rready} = 6'b1_0_0_0_0_0;
        i_arlen = 5'd4;
        @(negedge clk);
        s_arready = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            {i_arvalid, s_arready, s_rvalid, i_rready} = 4'b0_0_1_1;
            s_rdata = k;
            #1;
            chk($sformatf("rst_beat%0d", k), outs(), 32'b1000_1010);
        end
        @(negedge clk);
        s_rdata = 32'h3;
        rst_n = 1'b0;
        #1;
        chk("rst_outs_zero", outs(), 32'b0);
        chk("rst_rdata_zero", i_rdata, 32'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        s_rvalid = 1'b0;
        #1;
        chk("stray_sets_perr", outs(), 32'b0000_0001);
        @(negedge clk);
        #1;
        chk("perr_sticky", outs(), 32'b0000_0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
